// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file and interrupt controller that sits beside the MW stage.
// It holds mstatus/mie/mip/mepc/mcause/mtvec and executes CSRRW/CSRRS/CSRRC.
// It prioritises the platform, timer and external interrupts and issues a
// registered one-cycle redirect on trap entry or mret. The redirect also
// flushes the pipeline.
module csr_irq_unit #(
  parameter int                 NUM_IRQ   = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
  parameter logic [31:0]        RESET_VEC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        csr_addr,
  input  logic [1:0]         csr_op,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  input  logic [31:0]        csr_pc,
  input  logic               mret,
  input  logic               timer_irq,
  input  logic               ext_irq,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  // Writable mie bits: timer (7), external (11) and the platform field at 16+.
  localparam logic [31:0] IRQ_BITS = ((32'd1 << NUM_IRQ) - 32'd1) << 16;
  localparam logic [31:0] MIE_MASK = IRQ_BITS | 32'h0000_0880;

  typedef enum logic [1:0] {ST_RUN, ST_TRAP, ST_RET} state_t;

  state_t             state_q,          state_d;
  logic               mst_mie_q,        mst_mie_d;
  logic               mst_mpie_q,       mst_mpie_d;
  logic [31:0]        mie_q,            mie_d;
  logic [31:0]        mepc_q,           mepc_d;
  logic [31:0]        mcause_q,         mcause_d;
  logic [31:0]        mtvec_q,          mtvec_d;
  logic [NUM_IRQ-1:0] edge_pend_q,      edge_pend_d;
  logic [NUM_IRQ-1:0] irq_s1_q,         irq_s1_d;
  logic [NUM_IRQ-1:0] irq_s2_q,         irq_s2_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [31:0]        redirect_pc_q,    redirect_pc_d;

  logic [NUM_IRQ-1:0] irq_lines;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] edge_clr;
  logic [31:0]        mip;
  logic [31:0]        mstatus;
  logic [31:0]        pend;
  logic               take;
  logic [4:0]         code;
  logic [31:0]        vec_base;
  logic [31:0]        vector;
  logic               csr_hit;
  logic [31:0]        wr_val;
  logic               wr_en;

  // Edge-latched lines report the pending flop; level lines pass straight through.
  assign irq_lines = (irq_i & ~EDGE_MASK) | (edge_pend_q & EDGE_MASK);
  assign irq_rise  = irq_s1_q & ~irq_s2_q & EDGE_MASK;

  // Assemble the architectural views of mip and mstatus.
  always_comb begin
    mip                 = '0;
    mip[7]              = timer_irq;
    mip[11]             = ext_irq;
    mip[16 +: NUM_IRQ]  = irq_lines;
    mstatus             = '0;
    mstatus[3]          = mst_mie_q;
    mstatus[7]          = mst_mpie_q;
  end

  assign pend = mip & mie_q;
  assign take = (pend != 32'd0) && mst_mie_q && (state_q == ST_RUN);

  // Pick the highest-priority cause: ext > timer > irq_i[0] > ... > irq_i[N-1].
  always_comb begin
    code = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[16 + i]) code = 5'(16 + i);
    end
    if (pend[7])  code = 5'd7;
    if (pend[11]) code = 5'd11;
  end

  assign vec_base = {mtvec_q[31:2], 2'b00};
  assign vector   = mtvec_q[0] ? (vec_base + {25'd0, code, 2'b00}) : vec_base;

  // Combinational CSR read of the old value; unknown addresses read as zero.
  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b1;
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = mstatus;
      ADDR_MIE:     csr_rdata = mie_q;
      ADDR_MTVEC:   csr_rdata = mtvec_q;
      ADDR_MEPC:    csr_rdata = mepc_q;
      ADDR_MCAUSE:  csr_rdata = mcause_q;
      ADDR_MIP:     csr_rdata = mip;
      default:      csr_hit   = 1'b0;
    endcase
  end

  assign csr_illegal = (csr_op != OP_NONE) && !csr_hit;

  // Compute the write value and whether it may commit this cycle.
  always_comb begin
    case (csr_op)
      OP_RW:   wr_val = csr_wdata;
      OP_RS:   wr_val = csr_rdata | csr_wdata;
      OP_RC:   wr_val = csr_rdata & ~csr_wdata;
      default: wr_val = csr_rdata;
    endcase
    wr_en = (csr_op != OP_NONE) && csr_hit && (state_q == ST_RUN) && !take &&
            !(((csr_op == OP_RS) || (csr_op == OP_RC)) && (csr_wdata == 32'd0));
  end

  // Next-state logic: CSR writes first, then trap/mret updates override them.
  always_comb begin
    state_d          = state_q;
    mst_mie_d        = mst_mie_q;
    mst_mpie_d       = mst_mpie_q;
    mie_d            = mie_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtvec_d          = mtvec_q;
    irq_s1_d         = irq_i;
    irq_s2_d         = irq_s1_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    edge_clr         = '0;

    if (wr_en) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mst_mie_d  = wr_val[3];
          mst_mpie_d = wr_val[7];
        end
        ADDR_MIE:    mie_d    = wr_val & MIE_MASK;
        ADDR_MEPC:   mepc_d   = {wr_val[31:2], 2'b00};
        ADDR_MCAUSE: mcause_d = wr_val;
        // Reserved modes (>= 2) collapse to direct.
        ADDR_MTVEC:  mtvec_d  = {wr_val[31:2], 1'b0, (wr_val[1] ? 1'b0 : wr_val[0])};
        ADDR_MIP: begin
          if (csr_op == OP_RC) edge_clr = csr_wdata[16 +: NUM_IRQ] & EDGE_MASK;
        end
        default: ;
      endcase
    end

    for (int i = 0; i < NUM_IRQ; i++) begin
      if (take && (code == 5'(16 + i))) edge_clr[i] = edge_clr[i] | EDGE_MASK[i];
    end
    // A new rising edge wins over a clear in the same cycle.
    edge_pend_d = (edge_pend_q & ~edge_clr) | irq_rise;

    case (state_q)
      ST_RUN: begin
        if (take) begin
          state_d          = ST_TRAP;
          mepc_d           = csr_pc & ~32'h3;
          mcause_d         = {1'b1, 26'd0, code};
          mst_mpie_d       = mst_mie_q;
          mst_mie_d        = 1'b0;
          redirect_pc_d    = vector;
          redirect_valid_d = 1'b1;
        end else if (mret) begin
          state_d          = ST_RET;
          mst_mie_d        = mst_mpie_q;
          mst_mpie_d       = 1'b1;
          redirect_pc_d    = mepc_q;
          redirect_valid_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Register all state and the redirect outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_RUN;
      mst_mie_q        <= 1'b0;
      mst_mpie_q       <= 1'b0;
      mie_q            <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtvec_q          <= RESET_VEC;
      edge_pend_q      <= '0;
      irq_s1_q         <= '0;
      irq_s2_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      mst_mie_q        <= mst_mie_d;
      mst_mpie_q       <= mst_mpie_d;
      mie_q            <= mie_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtvec_q          <= mtvec_d;
      edge_pend_q      <= edge_pend_d;
      irq_s1_q         <= irq_s1_d;
      irq_s2_q         <= irq_s2_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule
